// File: rtl/bp_redirect_ctrl.sv
// Next-PC controller for the miniRV pipeline: owns the IF-stage PC and a
// 2-bit saturating branch history table. It arbitrates between EX
// misprediction redirects, load-use stalls, ID predicted redirects and
// sequential fetch. It also raises the pipeline flush strobes and counts
// EX redirects.
module bp_redirect_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 4
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        stall_if,
  input  logic        id_valid,
  input  logic [6:0]  id_opcode,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_j_imm,
  input  logic [31:0] id_b_imm,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jalr,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  output logic [31:0] pc,
  output logic        id_pred_taken,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [31:0] mispred_cnt
);

  localparam int          BHT_N     = 1 << BHT_IDX_W;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  logic [1:0] bht [BHT_N];

  logic [BHT_IDX_W-1:0] id_idx;
  logic [BHT_IDX_W-1:0] ex_idx;
  logic                 is_jal;
  logic                 is_b;
  logic                 pred_raw;
  logic [31:0]          id_target;
  logic                 b_miss;
  logic                 j_miss;
  logic                 ex_redirect;
  logic [31:0]          fix_pc;
  logic [31:0]          next_pc;
  logic                 bht_upd;
  logic [1:0]           bht_old;
  logic [1:0]           bht_new;

  assign id_idx = id_pc[BHT_IDX_W+1:2];
  assign ex_idx = ex_pc[BHT_IDX_W+1:2];

  // ID-stage prediction: jal always taken, B-type follows the counter MSB.
  // The BHT read sees the pre-update value; there is no bypass from EX.
  always_comb begin
    is_jal    = id_valid && (id_opcode == OP_JAL);
    is_b      = id_valid && (id_opcode == OP_BRANCH);
    pred_raw  = is_jal || (is_b && bht[id_idx][1]);
    id_target = id_pc + (is_jal ? id_j_imm : id_b_imm);
  end

  // EX-stage resolution: jalr is never predicted, so it always redirects.
  always_comb begin
    b_miss      = ex_valid && ex_is_branch && (ex_taken != ex_pred_taken);
    j_miss      = ex_valid && ex_is_jalr;
    ex_redirect = b_miss || j_miss;
    fix_pc      = (j_miss || ex_taken) ? ex_target : ex_pc + 32'd4;
  end

  // Next-PC priority: EX redirect beats stall. A stall suppresses the ID
  // redirect, and that redirect is taken again once the stall clears.
  always_comb begin
    if (ex_redirect)   next_pc = fix_pc;
    else if (stall_if) next_pc = pc;
    else if (pred_raw) next_pc = id_target;
    else               next_pc = pc + 32'd4;
  end

  // Strobes and prediction are combinational and held low during reset.
  always_comb begin
    id_pred_taken = !cpu_rst && pred_raw;
    flush_idex    = !cpu_rst && ex_redirect;
    flush_ifid    = !cpu_rst && (ex_redirect || (!stall_if && pred_raw));
  end

  // Saturating counter step for the resolving branch.
  always_comb begin
    bht_upd = ex_valid && ex_is_branch;
    bht_old = bht[ex_idx];
    bht_new = bht_old;
    if (ex_taken && (bht_old != 2'b11))       bht_new = bht_old + 2'd1;
    else if (!ex_taken && (bht_old != 2'b00)) bht_new = bht_old - 2'd1;
  end

  // PC, misprediction counter and BHT state.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      pc          <= RESET_PC;
      mispred_cnt <= 32'd0;
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else begin
      pc <= next_pc;
      if (ex_redirect) mispred_cnt <= mispred_cnt + 32'd1;
      if (bht_upd)     bht[ex_idx] <= bht_new;
    end
  end

endmodule
